// File: rtl/dmem_arbiter.sv
// dmem_arbiter: req/ack arbiter that shares one single-port data memory between the CPU and the UART loader.
// Optional macro DMEM_ARB_BOOT_HOLD_EN adds boot_done and keeps the CPU off memory until boot completes.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int CPU_PRIORITY = 1,
    parameter int MAX_WAIT     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DMEM_ARB_BOOT_HOLD_EN
    input  logic                  boot_done,
`endif
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  uart_req,
    input  logic                  uart_we,
    input  logic [ADDR_WIDTH-1:0] uart_addr,
    input  logic [DATA_WIDTH-1:0] uart_wdata,
    output logic                  uart_ack,
    output logic [DATA_WIDTH-1:0] uart_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam bit                PRIO_EN    = (CPU_PRIORITY != 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        UART_ACC = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_UART = 1'b1
    } grant_t;

    state_t                r_state;
    state_t                w_state_next;
    grant_t                r_last_grant;
    grant_t                w_last_grant_next;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [WAIT_W-1:0]     w_wait_cnt_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_next;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] w_mem_wdata_next;
    logic                  r_latched_we;
    logic                  w_latched_we_next;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_uart_rdata;

    logic                  w_cpu_elig;
    logic                  w_contested;
    logic                  w_grant_cpu;
    logic                  w_grant_uart;
    logic                  w_cpu_acc;
    logic                  w_uart_acc;

`ifdef DMEM_ARB_BOOT_HOLD_EN
    logic r_boot_ok;

    // Sticky: once the loader signals completion the CPU stays eligible until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_boot_ok <= 1'b0;
        end else if (boot_done) begin
            r_boot_ok <= 1'b1;
        end
    end

    assign w_cpu_elig = cpu_req & r_boot_ok;
`else
    assign w_cpu_elig = cpu_req;
`endif

    assign w_contested = w_cpu_elig & uart_req;

    // Grant decision; only meaningful in IDLE, forced low elsewhere.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_grant_cpu  = 1'b0;
        w_grant_uart = 1'b0;
        if (r_state == IDLE) begin
            if (w_contested) begin
                if (!PRIO_EN) begin
                    if (r_last_grant == GRANT_UART) begin
                        w_grant_cpu = 1'b1;
                    end else begin
                        w_grant_uart = 1'b1;
                    end
                end else if (r_wait_cnt == WAIT_LIMIT) begin
                    w_grant_uart = 1'b1;
                end else begin
                    w_grant_cpu = 1'b1;
                end
            end else begin
                w_grant_cpu  = w_cpu_elig;
                w_grant_uart = uart_req;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_wait_cnt_next   = r_wait_cnt;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_latched_we_next = r_latched_we;
        case (r_state)
            IDLE: begin
                if (w_grant_cpu) begin
                    w_state_next      = CPU_ACC;
                    w_last_grant_next = GRANT_CPU;
                    w_mem_addr_next   = cpu_addr;
                    w_mem_wdata_next  = cpu_wdata;
                    w_latched_we_next = cpu_we;
                    // Starvation guard counts only wins the UART actually lost.
                    if (PRIO_EN && w_contested) begin
                        w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
                    end
                end else if (w_grant_uart) begin
                    w_state_next      = UART_ACC;
                    w_last_grant_next = GRANT_UART;
                    w_mem_addr_next   = uart_addr;
                    w_mem_wdata_next  = uart_wdata;
                    w_latched_we_next = uart_we;
                    w_wait_cnt_next   = '0;
                end
            end
            CPU_ACC, UART_ACC: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_UART;
            r_wait_cnt   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_latched_we <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_wait_cnt   <= w_wait_cnt_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_latched_we <= w_latched_we_next;
        end
    end

    assign w_cpu_acc  = (r_state == CPU_ACC);
    assign w_uart_acc = (r_state == UART_ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rdata  <= '0;
            r_uart_rdata <= '0;
        end else begin
            if (w_cpu_acc && !r_latched_we) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (w_uart_acc && !r_latched_we) begin
                r_uart_rdata <= mem_rdata;
            end
        end
    end

    // Moore-decoded from state, so reset drops mem_we and the acks without waiting for a clock.
    assign cpu_ack    = w_cpu_acc;
    assign uart_ack   = w_uart_acc;
    assign mem_we     = (w_cpu_acc | w_uart_acc) & r_latched_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_rdata  = (w_cpu_acc && !r_latched_we) ? mem_rdata : r_cpu_rdata;
    assign uart_rdata = (w_uart_acc && !r_latched_we) ? mem_rdata : r_uart_rdata;

endmodule
